// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit holding architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per clock.
module mul_div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs_data,
   input  logic [XLEN-1:0] rt_data,
   input  logic            hi_we,
   input  logic            lo_we,
   input  logic [XLEN-1:0] mt_data,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   localparam int unsigned CntW = $clog2(XLEN);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              is_div_q, is_div_d;
   logic              div0_q, div0_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]   opb_q, opb_d;
   logic [XLEN-1:0]   acc_hi_q, acc_hi_d;
   logic [XLEN-1:0]   acc_lo_q, acc_lo_d;
   logic [XLEN-1:0]   hi_q, hi_d;
   logic [XLEN-1:0]   lo_q, lo_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              op_signed;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;

   always_comb begin
      op_signed = ~op[0];
      a_neg     = op_signed & rs_data[XLEN-1];
      b_neg     = op_signed & rt_data[XLEN-1];
      a_mag     = a_neg ? (~rs_data) + XLEN'(1) : rs_data;
      b_mag     = b_neg ? (~rt_data) + XLEN'(1) : rt_data;

      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
      div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opb_q};

      prod      = {acc_hi_q, acc_lo_q};
      prod_fix  = neg_res_q ? (~prod) + (2*XLEN)'(1) : prod;
      quo_fix   = neg_res_q ? (~acc_lo_q) + XLEN'(1) : acc_lo_q;
      // A zero divisor leaves the dividend magnitude in the remainder, so the
      // sign fix-up restores the raw latched rs value.
      rem_fix   = neg_rem_q ? (~acc_hi_q) + XLEN'(1) : acc_hi_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      div0_d    = div0_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      opb_d     = opb_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StCalc;
               busy_d    = 1'b1;
               cnt_d     = '0;
               is_div_d  = op[1];
               div0_d    = op[1] & (rt_data == '0);
               neg_res_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               opb_d     = op[1] ? b_mag : a_mag;
               acc_hi_d  = '0;
               acc_lo_d  = op[1] ? a_mag : b_mag;
            end else begin
               if (hi_we) hi_d = mt_data;
               if (lo_we) lo_d = mt_data;
            end
         end
         StCalc: begin
            if (is_div_q) begin
               // Restoring step: keep the trial difference only when it did not borrow.
               if (!div_diff[XLEN]) begin
                  acc_hi_d = div_diff[XLEN-1:0];
                  acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
               end else begin
                  acc_hi_d = div_shift[XLEN-1:0];
                  acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
               end
            end else begin
               acc_hi_d = mul_sum[XLEN:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
            end
            if (cnt_q == CntW'(XLEN - 1)) begin
               state_d = StFix;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StFix: begin
            if (is_div_q) begin
               lo_d = div0_q ? {XLEN{1'b1}} : quo_fix;
               hi_d = rem_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         div0_q    <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opb_q     <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         div0_q    <= div0_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         opb_q     <= opb_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, MTHI/MTLO and reset behaviour.
module tb_mul_div_unit;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        start   = 1'b0;
   logic [1:0]  op      = 2'b00;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        hi_we   = 1'b0;
   logic        lo_we   = 1'b0;
   logic [31:0] mt_data = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   mul_div_unit #(.XLEN(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .op      (op),
      .rs_data (rs_data),
      .rt_data (rt_data),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .mt_data (mt_data),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // mode 0: plain; 1: extra start mid-op; 2: MTLO mid-op; 3: MTHI/MTLO together with start
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int mode,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int          nbusy;
      bit          seen;
      bit          busy_at_done;
      logic [31:0] hi0;
      logic [31:0] lo0;
      @(negedge clk);
      hi0     = hi;
      lo0     = lo;
      op      = o;
      rs_data = a;
      rt_data = b;
      start   = 1'b1;
      if (mode == 3) begin
         hi_we   = 1'b1;
         lo_we   = 1'b1;
         mt_data = 32'h1234_5678;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      nbusy = 0;
      seen  = 1'b0;
      busy_at_done = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            busy_at_done = busy;
         end else if (busy) begin
            nbusy++;
         end
         if (i == 10) begin
            check_eq({tag, " hilo hold"}, {hi, lo}, {hi0, lo0});
            if (mode == 1) begin
               start   = 1'b1;
               op      = 2'b01;
               rs_data = 32'd2;
               rt_data = 32'd2;
            end
            if (mode == 2) begin
               lo_we   = 1'b1;
               mt_data = 32'hDEAD_BEEF;
            end
         end
         if (i == 11) begin
            start = 1'b0;
            lo_we = 1'b0;
         end
      end
      check_eq({tag, " done seen"}, 64'(seen), 64'd1);
      check_eq({tag, " busy cycles"}, 64'(nbusy), 64'd33);
      check_eq({tag, " busy at done"}, 64'(busy_at_done), 64'd0);
      check_eq({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check_eq({tag, " lo"}, 64'(lo), 64'(exp_lo));
      @(negedge clk);
      check_eq({tag, " done pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int ndone;
      #12;
      check_eq("reset hi", 64'(hi), 64'd0);
      check_eq("reset lo", 64'(lo), 64'd0);
      check_eq("reset busy", 64'(busy), 64'd0);
      check_eq("reset done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("MULT -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("MULTU max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
             32'hFFFF_FFFE, 32'h0000_0001);
      run_op("MULTU small", 2'b01, 32'h1234_5678, 32'h10, 0, 32'h0000_0001, 32'h2345_6780);
      run_op("DIV -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("DIV 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 3, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("DIV ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000);
      run_op("DIVU by 0", 2'b11, 32'd100, 32'd0, 0, 32'd100, 32'hFFFF_FFFF);
      run_op("DIV 100/7 mtlo", 2'b10, 32'd100, 32'd7, 2, 32'd2, 32'd14);

      // MTHI alone, then both strobes together
      @(negedge clk);
      hi_we   = 1'b1;
      mt_data = 32'hA5A5_A5A5;
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      check_eq("MTHI hi", 64'(hi), 64'hA5A5_A5A5);
      check_eq("MTHI lo kept", 64'(lo), 64'd14);
      @(negedge clk);
      hi_we   = 1'b1;
      lo_we   = 1'b1;
      mt_data = 32'h0F0F_0F0F;
      @(posedge clk);
      #1;
      hi_we = 1'b0;
      lo_we = 1'b0;
      check_eq("MTHI+MTLO", {hi, lo}, {32'h0F0F_0F0F, 32'h0F0F_0F0F});

      // Reset mid-operation discards the divide
      @(negedge clk);
      op      = 2'b11;
      rs_data = 32'd1000;
      rt_data = 32'd7;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("async rst busy", 64'(busy), 64'd0);
      check_eq("async rst done", 64'(done), 64'd0);
      check_eq("async rst hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check_eq("no done after rst", 64'(ndone), 64'd0);
      check_eq("idle after rst", {31'd0, busy, hi, lo}, 64'd0);
      run_op("DIVU 1000/7", 2'b11, 32'd1000, 32'd7, 0, 32'd6, 32'd142);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
